// File: rtl/ime_frame_scheduler_pkg.sv
// IME shared package: scheduler/framer state enum, mode width, reset
// defaults and the one-hot mode check shared with the joint framer.
package ime_frame_scheduler_pkg;

  localparam int IME_MODE_W = 5;

  localparam logic [15:0] IME_LEN_RST = 16'd1;
  localparam logic [IME_MODE_W-1:0] IME_MODE_RST = 5'b00001;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ime_state_e;

  function automatic logic ime_is_onehot(
    input logic [IME_MODE_W-1:0] m
  );
    return (m != '0) && ((m & (m - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/ime_frame_scheduler_arb.sv
// Round-robin selector: first asserted request at or after i_ptr, wrapping.
// Ports: i_req (request vector), i_ptr (start index), o_grant, o_any.
module ime_rr_arbiter
  import ime_frame_scheduler_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_grant,
  output logic            o_any
);

  always_comb begin
    o_any   = 1'b0;
    o_grant = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!o_any && i_req[(int'(i_ptr) + k) % N_CH]) begin
        o_any   = 1'b1;
        o_grant = IW'((int'(i_ptr) + k) % N_CH);
      end
    end
  end

endmodule

// File: rtl/ime_frame_scheduler.sv
// Frame scheduler: grants one probability stream per frame to the joint
// framer. Ports: per-channel req_* beats in, fr_* beats out, cfg_* strobe,
// grant_ch/busy/frames_done status. Sync active-high rst.
module ime_frame_scheduler
  import ime_frame_scheduler_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W_P  = 16,
  parameter int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       req_valid,
  output logic [N_CH-1:0]       req_ready,
  input  logic [N_CH*W_P-1:0]   req_p_joint,
  input  logic [N_CH*W_P-1:0]   req_p_marg_x,
  input  logic [N_CH*W_P-1:0]   req_p_marg_y,
  input  logic [N_CH-1:0]       req_last,
  input  logic [N_CH-1:0]       req_poison,
  input  logic [15:0]           cfg_frame_len,
  input  logic [IME_MODE_W-1:0] cfg_mode_onehot,
  input  logic                  cfg_update,
  output logic                  fr_valid,
  input  logic                  fr_ready,
  output logic [W_P-1:0]        fr_p_joint,
  output logic [W_P-1:0]        fr_p_marg_x,
  output logic [W_P-1:0]        fr_p_marg_y,
  output logic                  fr_last,
  output logic                  fr_poison,
  output logic [15:0]           fr_frame_len,
  output logic [IME_MODE_W-1:0] fr_mode_onehot,
  output logic [IW-1:0]         grant_ch,
  output logic                  busy,
  output logic [15:0]           frames_done
);

  ime_state_e r_state, w_state_nx;

  logic [IW-1:0] r_grant, r_rr_ptr;
  logic [IW-1:0] w_arb_idx, w_ptr_nx;
  logic          w_arb_any;

  logic [15:0] r_beat, r_frames_done;
  logic [15:0] r_len_pend, r_len_act;
  logic [15:0] w_len_pend_nx, w_len_eff;

  logic [IME_MODE_W-1:0] r_mode_pend, r_mode_act;
  logic [IME_MODE_W-1:0] w_mode_pend_nx;

  logic w_stream, w_hs, w_end, w_len_hit, w_bad_mode;
  logic w_sel_valid, w_sel_last, w_sel_poison;
  logic [W_P-1:0] w_pj, w_px, w_py;

  ime_rr_arbiter #(.N_CH(N_CH), .IW(IW)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_idx),
    .o_any   (w_arb_any)
  );

  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_last   = 1'b0;
    w_sel_poison = 1'b0;
    w_pj         = '0;
    w_px         = '0;
    w_py         = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_grant == IW'(i)) begin
        w_sel_valid  = req_valid[i];
        w_sel_last   = req_last[i];
        w_sel_poison = req_poison[i];
        w_pj         = req_p_joint[i*W_P +: W_P];
        w_px         = req_p_marg_x[i*W_P +: W_P];
        w_py         = req_p_marg_y[i*W_P +: W_P];
      end
    end
  end

  // pending values as they will be after this edge, so a strobe
  // coinciding with a grant still lands in the new frame
  assign w_len_pend_nx  = cfg_update ? cfg_frame_len : r_len_pend;
  assign w_mode_pend_nx = cfg_update ? cfg_mode_onehot : r_mode_pend;

  assign w_stream   = (r_state == ST_STREAM);
  assign w_len_eff  = (r_len_act == 16'd0) ? 16'd1 : r_len_act;
  assign w_len_hit  = ({1'b0, r_beat} + 17'd1) >= {1'b0, w_len_eff};
  assign w_end      = w_sel_last | w_len_hit;
  assign w_hs       = w_stream & w_sel_valid & fr_ready;
  assign w_bad_mode = (r_mode_act != '0) & ~ime_is_onehot(r_mode_act);
  assign w_ptr_nx   = (r_grant == IW'(N_CH - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_arb_any) w_state_nx = ST_STREAM;
      ST_STREAM: if (w_hs && w_end) w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_beat        <= '0;
      r_frames_done <= '0;
      r_len_pend    <= IME_LEN_RST;
      r_len_act     <= IME_LEN_RST;
      r_mode_pend   <= IME_MODE_RST;
      r_mode_act    <= IME_MODE_RST;
    end else begin
      if (cfg_update) begin
        r_len_pend  <= cfg_frame_len;
        r_mode_pend <= cfg_mode_onehot;
      end
      if (r_state == ST_IDLE) begin
        r_len_act  <= w_len_pend_nx;
        r_mode_act <= w_mode_pend_nx;
        if (w_arb_any) r_grant <= w_arb_idx;
      end
      if (w_hs) begin
        if (w_end) begin
          r_beat        <= '0;
          r_rr_ptr      <= w_ptr_nx;
          r_frames_done <= r_frames_done + 16'd1;
        end else begin
          r_beat <= r_beat + 16'd1;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_stream && r_grant == IW'(i)) req_ready[i] = fr_ready;
    end
  end

  assign fr_valid       = w_stream & w_sel_valid;
  assign fr_p_joint     = w_pj;
  assign fr_p_marg_x    = w_px;
  assign fr_p_marg_y    = w_py;
  assign fr_last        = fr_valid & w_end;
  assign fr_poison      = fr_valid & (w_bad_mode | w_sel_poison);
  assign fr_frame_len   = r_len_act;
  assign fr_mode_onehot = r_mode_act;
  assign grant_ch       = r_grant;
  assign busy           = w_stream;
  assign frames_done    = r_frames_done;

endmodule

// File: tb/tb_ime_frame_scheduler.sv
// Self-checking bench for ime_frame_scheduler: directed scenarios plus
// randomized traffic against a frame-level reference model.
module tb_ime_frame_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, req_last, req_poison;
  logic [N*W-1:0] req_p_joint, req_p_marg_x, req_p_marg_y;
  logic [15:0]    cfg_frame_len;
  logic [4:0]     cfg_mode_onehot;
  logic           cfg_update;
  logic           fr_valid, fr_ready, fr_last, fr_poison;
  logic [W-1:0]   fr_p_joint, fr_p_marg_x, fr_p_marg_y;
  logic [15:0]    fr_frame_len;
  logic [4:0]     fr_mode_onehot;
  logic [1:0]     grant_ch;
  logic           busy;
  logic [15:0]    frames_done;

  always #5 clk = ~clk;

  ime_frame_scheduler #(.N_CH(N), .W_P(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_p_joint(req_p_joint), .req_p_marg_x(req_p_marg_x),
    .req_p_marg_y(req_p_marg_y),
    .req_last(req_last), .req_poison(req_poison),
    .cfg_frame_len(cfg_frame_len), .cfg_mode_onehot(cfg_mode_onehot),
    .cfg_update(cfg_update),
    .fr_valid(fr_valid), .fr_ready(fr_ready),
    .fr_p_joint(fr_p_joint), .fr_p_marg_x(fr_p_marg_x),
    .fr_p_marg_y(fr_p_marg_y),
    .fr_last(fr_last), .fr_poison(fr_poison),
    .fr_frame_len(fr_frame_len), .fr_mode_onehot(fr_mode_onehot),
    .grant_ch(grant_ch), .busy(busy), .frames_done(frames_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model: who owns the stream, beats so far, config, log
  bit          m_busy;
  int          m_owner, m_ptr, m_beats, m_pcnt;
  logic [15:0] m_done, m_len_a, m_len_p;
  logic [4:0]  m_mode_a, m_mode_p;
  int          q_own[$], q_len[$], q_pois[$];

  bit e_valid, e_last, e_poison;
  int scn;
  bit d_done;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] sl(input logic [N*W-1:0] v, input int c);
    return v[c*W +: W];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_pcnt = 0;
    m_done = 0; m_len_a = 1; m_len_p = 1;
    m_mode_a = 5'b00001; m_mode_p = 5'b00001;
  endtask

  task automatic check();
    int lim;
    logic [N-1:0] rdy;
    e_valid = m_busy && req_valid[m_owner];
    lim = (m_len_a == 0) ? 1 : int'(m_len_a);
    e_last = req_last[m_owner] || (m_beats + 1 >= lim);
    e_poison = req_poison[m_owner] ||
               (m_mode_a != 0 && $countones(m_mode_a) != 1);
    rdy = '0;
    if (m_busy) rdy[m_owner] = fr_ready;
    chk("busy", busy, m_busy);
    chk("grant_ch", grant_ch, m_owner);
    chk("fr_valid", fr_valid, e_valid);
    chk("req_ready", req_ready, rdy);
    chk("frames_done", frames_done, m_done);
    chk("fr_frame_len", fr_frame_len, m_len_a);
    chk("fr_mode", fr_mode_onehot, m_mode_a);
    if (e_valid) begin
      chk("p_joint", fr_p_joint, sl(req_p_joint, m_owner));
      chk("p_marg_x", fr_p_marg_x, sl(req_p_marg_x, m_owner));
      chk("p_marg_y", fr_p_marg_y, sl(req_p_marg_y, m_owner));
      chk("fr_last", fr_last, e_last);
      chk("fr_poison", fr_poison, e_poison);
    end
  endtask

  task automatic advance();
    logic [15:0] lp;
    logic [4:0]  mp;
    int c;
    if (rst) begin
      model_reset();
      return;
    end
    lp = cfg_update ? cfg_frame_len : m_len_p;
    mp = cfg_update ? cfg_mode_onehot : m_mode_p;
    m_len_p = lp;
    m_mode_p = mp;
    if (!m_busy) begin
      m_len_a = lp;
      m_mode_a = mp;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!m_busy && req_valid[c]) begin
          m_busy = 1; m_owner = c; m_beats = 0; m_pcnt = 0;
        end
      end
    end else if (e_valid && fr_ready) begin
      m_pcnt += int'(e_poison);
      if (e_last) begin
        q_own.push_back(m_owner);
        q_len.push_back(m_beats + 1);
        q_pois.push_back(m_pcnt);
        m_busy = 0; m_beats = 0; m_pcnt = 0;
        m_ptr = (m_owner + 1) % N;
        m_done = m_done + 16'd1;
      end else begin
        m_beats++;
      end
    end
  endtask

  task automatic cyc();
    #1;
    check();
    advance();
    @(negedge clk);
  endtask

  task automatic drive();
    req_p_joint  = {$urandom(), $urandom()};
    req_p_marg_x = {$urandom(), $urandom()};
    req_p_marg_y = {$urandom(), $urandom()};
    cfg_update = 0;
    rst = 0;
    req_last = '0;
    req_poison = '0;
    fr_ready = 1;
    case (scn)
      1: req_valid = 4'b0101;
      2: req_valid = 4'b1010;
      3: begin
        req_valid = 4'b1010;
        req_last[1] = m_busy && m_owner == 1 && m_beats == 1;
      end
      4: begin
        req_valid = 4'b0001;
        if (m_busy && m_beats == 1 && !d_done) begin
          cfg_update = 1; cfg_frame_len = 3;
          cfg_mode_onehot = 5'b00110; d_done = 1;
        end
      end
      default: begin
        req_valid  = 4'($urandom_range(0, 15));
        req_last   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        req_poison = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'b0;
        fr_ready   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) begin
          cfg_update = 1;
          cfg_frame_len = 16'($urandom_range(0, 6));
          cfg_mode_onehot = 5'($urandom_range(0, 31));
        end
        rst = ($urandom_range(0, 299) == 0);
      end
    endcase
  endtask

  task automatic setup(input logic [15:0] len, input logic [4:0] mode);
    rst = 1; req_valid = '0; req_last = '0; req_poison = '0;
    fr_ready = 1; cfg_update = 0;
    cyc();
    rst = 0; cfg_update = 1; cfg_frame_len = len; cfg_mode_onehot = mode;
    cyc();
    cfg_update = 0;
    cyc();
    q_own.delete(); q_len.delete(); q_pois.delete();
  endtask

  task automatic run_frames(input int nf, input int lim);
    int c = 0;
    while (q_own.size() < nf && c < lim) begin
      drive();
      cyc();
      c++;
    end
    chk("frames_reached", q_own.size(), nf);
  endtask

  initial begin
    rst = 1; req_valid = '0; req_last = '0; req_poison = '0;
    req_p_joint = '0; req_p_marg_x = '0; req_p_marg_y = '0;
    cfg_frame_len = 1; cfg_mode_onehot = 5'b00001; cfg_update = 0;
    fr_ready = 0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_fr_valid", fr_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_len", fr_frame_len, 1);
    chk("rst_mode", fr_mode_onehot, 5'b00001);
    chk("rst_done", frames_done, 0);
    @(negedge clk);

    // alternating grants, fixed length 4
    setup(4, 5'b00001); scn = 1;
    run_frames(4, 60);
    if (q_own.size() >= 4) begin
      chk("A_own0", q_own[0], 0); chk("A_own1", q_own[1], 2);
      chk("A_own2", q_own[2], 0); chk("A_own3", q_own[3], 2);
      chk("A_len0", q_len[0], 4); chk("A_len3", q_len[3], 4);
    end
    chk("A_done", frames_done, 4);

    // zero length means single-beat frames
    setup(0, 5'b00001); scn = 2;
    run_frames(4, 40);
    if (q_own.size() >= 4) begin
      chk("B_own0", q_own[0], 1); chk("B_own1", q_own[1], 3);
      chk("B_own2", q_own[2], 1); chk("B_len2", q_len[2], 1);
    end

    // early req_last
    setup(8, 5'b00001); scn = 3;
    run_frames(2, 60);
    if (q_own.size() >= 2) begin
      chk("C_own0", q_own[0], 1); chk("C_len0", q_len[0], 2);
      chk("C_own1", q_own[1], 3); chk("C_len1", q_len[1], 8);
    end

    // config change mid-frame applies to the next frame only
    setup(4, 5'b00001); scn = 4; d_done = 0;
    run_frames(2, 60);
    if (q_own.size() >= 2) begin
      chk("D_len0", q_len[0], 4); chk("D_pois0", q_pois[0], 0);
      chk("D_len1", q_len[1], 3); chk("D_pois1", q_pois[1], 3);
    end
    chk("D_frame_len", fr_frame_len, 3);

    // stall then reset mid-frame
    setup(8, 5'b00001); scn = 0;
    req_p_joint  = 64'h1111_2222_3333_4444;
    req_p_marg_x = 64'h5555_6666_7777_8888;
    req_p_marg_y = 64'h9999_aaaa_bbbb_cccc;
    req_valid = 4'b0100; fr_ready = 1;
    for (int c = 0; c < 20 && !(m_busy && m_beats == 2); c++) cyc();
    chk("E_reach", m_beats, 2);
    fr_ready = 0;
    for (int s = 0; s < 5; s++) begin
      cyc();
      #1;
      chk("E_stall_valid", fr_valid, 1);
      chk("E_stall_data", fr_p_joint, 16'h2222);
      chk("E_stall_ready", req_ready, 0);
    end
    rst = 1;
    cyc();
    rst = 0; req_valid = 4'b0101; fr_ready = 1;
    #1;
    chk("E_rst_valid", fr_valid, 0);
    chk("E_rst_done", frames_done, 0);
    chk("E_rst_busy", busy, 0);
    cyc();
    #1;
    chk("E_regrant", grant_ch, 0);
    chk("E_regrant_busy", busy, 1);
    cyc();

    // randomized traffic
    setup(3, 5'b00001); scn = 5;
    for (int i = 0; i < 4000; i++) begin
      drive();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ime_frame_scheduler.md
IME_FRAME_SCHEDULER -- requirements
Module: ime_frame_scheduler

Interface
REQ-001 Parameters SHALL be: N_CH, default 4, number of requesting probability streams; W_P, default 16, probability width.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid / req_ready  input / output  N_CH each  per-channel beat handshake.
REQ-005 req_p_joint, req_p_marg_x, req_p_marg_y  input  N_CH*W_P each  packed per-channel probabilities; channel i occupies bits [i*W_P +: W_P].
REQ-006 req_last, req_poison  input  N_CH each  per-channel end-of-frame and poison flags.
REQ-007 cfg_frame_len  input  16  beats per frame; cfg_mode_onehot  input  5  mode select; cfg_update  input  1  one-cycle strobe that captures both into pending registers.
REQ-008 fr_valid / fr_ready  output / input  1  beat handshake toward the joint framer.
REQ-009 fr_p_joint, fr_p_marg_x, fr_p_marg_y  output  W_P each; fr_last, fr_poison  output  1 each.
REQ-010 fr_frame_len  output  16 and fr_mode_onehot  output  5  active configuration driven to the framer.
REQ-011 grant_ch  output  $clog2(N_CH)  current owner; busy  output  1  high in STREAM; frames_done  output  16  completed-frame counter.

Function
REQ-012 FSM SHALL have two states: IDLE and STREAM.
REQ-013 In IDLE, if any req_valid is high, the block SHALL select the first requesting channel at or after rr_ptr (round-robin, wrapping) and enter STREAM next cycle with grant_ch registered.
REQ-014 In STREAM, fr_valid, data, fr_last-source and poison SHALL be combinationally muxed from channel grant_ch (zero added latency); req_ready[grant_ch] = fr_ready; all other req_ready SHALL be 0.
REQ-015 In IDLE, fr_valid and all req_ready SHALL be 0.
REQ-016 A beat-count register SHALL increment on each fr_valid&&fr_ready in STREAM; the frame SHALL end on a handshake where req_last[grant_ch] is high or beat_count+1 >= frame_len_eff; frame_len_eff = 1 when the active frame length is 0.
REQ-017 fr_last SHALL be high on exactly the frame-ending beat, including when the length limit (not req_last) terminates the frame.
REQ-018 On frame end: next state IDLE, beat count := 0, rr_ptr := grant_ch+1 modulo N_CH, frames_done += 1, wrapping 0xFFFF -> 0.
REQ-019 A granted channel that deasserts req_valid mid-frame SHALL keep the grant; no timeout or preemption.
REQ-020 cfg_update SHALL load the pending registers in any state; pending values SHALL be copied to the active registers only in IDLE, so fr_frame_len/fr_mode_onehot never change inside a frame.
REQ-021 If the active mode is nonzero and not exactly one-hot, fr_poison SHALL be forced 1 on every beat; otherwise fr_poison = req_poison[grant_ch].
REQ-022 cfg_update coinciding with an IDLE-to-STREAM transition SHALL take effect for that frame (pending-to-active copy uses the newly strobed value).
REQ-023 An IDLE cycle is mandatory between consecutive frames (minimum one bubble per frame).

Reset
REQ-024 With rst high at a clock edge: state := IDLE, rr_ptr := 0, grant_ch := 0, beat count := 0, frames_done := 0, active and pending frame_len := 1, mode := 5'b00001; hence fr_valid, req_ready, busy := 0, fr_frame_len := 1, fr_mode_onehot := 5'b00001.
REQ-025 Reset asserted mid-frame SHALL abandon the frame without emitting fr_last.

Structure
REQ-026 The state enum, IME_MODE_W = 5 and the one-hot check function SHALL live in the shared IME package, reused by the joint framer.
REQ-027 The round-robin selector SHALL be one sub-module, ime_rr_arbiter (request vector, pointer in; grant index, any-grant out).

Verification
REQ-028 Channels 0 and 2 request continuously, frame_len=4, no req_last -> grants alternate 0,2,0,2; fr_last on every 4th beat; frames_done increments by one per frame.
REQ-029 frame_len=0 -> every beat has fr_last=1 and is a full frame; rr_ptr advances each frame.
REQ-030 Channel 1 asserts req_last on beat 2 with frame_len=8 -> frame ends after 2 beats, fr_last on beat 2, next grant goes to the next requester after channel 1.
REQ-031 cfg_update with frame_len=3, mode=5'b00110 on beat 1 of a 4-beat frame -> current frame completes at 4 beats unpoisoned; next frame is 3 beats with fr_poison=1 on all beats.
REQ-032 fr_ready held low 5 cycles mid-frame, then rst pulsed -> data stable while stalled; after reset fr_valid=0, frames_done=0, grant restarts from channel 0.
